imm_ext_ctrl: RTL and testbench
===============================

# imm_ext_ctrl

Sequential immediate-generation controller for the ARM decode stage. It accepts a 32-bit instruction over a valid/ready handshake and derives `ImmSrc` from the op field. For data-processing immediates it performs the rotate iteratively, and it returns the 32-bit extended immediate over a second valid/ready handshake. It sits between instruction fetch and the register-read/execute datapath.

## Interface
- `ROT_STEP`, default 2: bits rotated per cycle in iterative mode; even, 2..30.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  block can accept an instruction.
- `Instr`  in  32  instruction word.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `ImmSrc`  out  2  decoded immediate class: 00 DP, 01 memory, 10 branch, 11 illegal.
- `ExtImm`  out  32  extended immediate.
- `busy`  out  1  high in ROTATE or DONE.
- `illegal`  out  1  op field = 11 for the current result.

## Operation
- Op field is `Instr[27:26]`.
- FSM states: IDLE, ROTATE, DONE.
- IDLE:
  - `in_ready`=1.
  - Accept on `in_valid & in_ready`.
  - Latch `Instr`.
  - Set `ImmSrc` = op.
- Decode on accept:
  - op=00: working value = {24'b0, `Instr[7:0]`}; remaining = 2×`Instr[11:8]` (6-bit). If remaining=0, go to DONE. Otherwise go to ROTATE.
  - op=01: `ExtImm` = {20'b0, `Instr[11:0]`}; go to DONE.
  - op=10: `ExtImm` = {6×`Instr[23]`, `Instr[23:0]`, 2'b00}; go to DONE.
  - op=11: `ExtImm`=0, `illegal`=1; go to DONE.
- ROTATE, each cycle:
  - step = min(`ROT_STEP`, remaining).
  - working value rotated right by step.
  - remaining -= step.
  - When remaining becomes 0, load `ExtImm` and go to DONE.
- DONE:
  - `out_valid`=1.
  - `ExtImm`, `ImmSrc` and `illegal` held stable until `out_valid & out_ready`, then go to IDLE.
- `in_ready`=0 in ROTATE and DONE. No accept in the same cycle as output handshake.
- Rotation is true circular: wrap-around bits re-enter at the MSB. Rotate by 32 never occurs (max 30).

## Timing
- All outputs are registered or decoded from state.
- Reset values:
  - state IDLE, `in_ready`=1.
  - `out_valid`=0, `ExtImm`=0, `ImmSrc`=00, `busy`=0, `illegal`=0.
- Latency, counted from the accept edge to `out_valid` high:
  - Non-rotating results: 1 cycle.
  - Rotating results: 1 + ceil(2×rot / `ROT_STEP`) cycles.
- Throughput: at most one instruction per (latency + 1) cycles.
- Reset in ROTATE or DONE aborts immediately: outputs go to reset values, and the partial result is discarded.
- `out_ready` high before `out_valid` has no effect.
- `in_valid` held during busy is ignored. The source must hold `Instr` until accepted.

## Configuration
- `IMM_FAST_ROT_EN` defined:
  - Combinational barrel rotator; ROTATE state is never entered.
  - All classes complete in 1 cycle.
  - `ROT_STEP` is ignored.
- `IMM_FAST_ROT_EN` undefined: iterative rotation as above, so less area.
- The function of `ExtImm` is identical in both builds.

## Test plan
- `Instr`=0xE3A010FF, `out_ready`=1 -> `ExtImm`=0x000000FF, `ImmSrc`=00, `out_valid` 1 cycle after accept.
- `Instr`=0xE3A014FF, `ROT_STEP`=2 -> `ExtImm`=0xFF000000, `out_valid` 5 cycles after accept (1 cycle with `IMM_FAST_ROT_EN`). Also `Instr[11:0]`=0xF01 -> `ExtImm`=0x00000004 (wrap).
- `Instr`=0xE5912ABC -> `ExtImm`=0x00000ABC, `ImmSrc`=01.
- `Instr`=0xEAFFFFFE -> `ExtImm`=0xFFFFFFF8, `ImmSrc`=10. Then `Instr`=0x0C000000 -> `ImmSrc`=11, `ExtImm`=0, `illegal`=1.
- `out_ready` low 3 cycles in DONE, second `in_valid` pulsed -> `ExtImm` stable, `in_ready`=0, second word accepted only after output handshake.
- `reset` low mid-ROTATE -> all outputs at reset values asynchronously; next transaction (0xE3A014FF) yields 0xFF000000.

Source files
------------

// File: rtl/imm_ext_ctrl.sv
// Immediate-generation controller: decodes the ARM immediate class and rotates DP immediates.
// Define IMM_FAST_ROT_EN for a single-cycle barrel rotator instead of the iterative one.
module imm_ext_ctrl #(
  parameter int ROT_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  ImmSrc,
  output logic [31:0] ExtImm,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [5:0] STEP = 6'(ROT_STEP);

  state_t      state_r, state_s;
  logic [31:0] work_r, work_s;
  logic [5:0]  rem_r, rem_s;
  logic [31:0] ext_r, ext_s;
  logic [1:0]  src_r, src_s;
  logic        ill_r, ill_s;

  logic [1:0]  op_s;
  logic [31:0] imm8_s;
  logic [5:0]  rot2_s;
  logic [5:0]  step_s;
  logic [31:0] work_rot_s;
  logic [5:0]  rem_dec_s;
  logic        unused_s;

  function automatic logic [31:0] rotr(input logic [31:0] v, input logic [5:0] sh);
    logic [63:0] d;
    d = {v, v} >> sh;
    return d[31:0];
  endfunction

  assign op_s       = Instr[27:26];
  assign imm8_s     = {24'd0, Instr[7:0]};
  assign rot2_s     = {1'b0, Instr[11:8], 1'b0};
  assign step_s     = (rem_r < STEP) ? rem_r : STEP;
  assign work_rot_s = rotr(work_r, step_s);
  assign rem_dec_s  = rem_r - step_s;
  assign unused_s   = ^{Instr[31:28], Instr[25:24]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: working value, remaining rotation and held result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_r <= 32'd0;
      rem_r  <= 6'd0;
      ext_r  <= 32'd0;
      src_r  <= 2'b00;
      ill_r  <= 1'b0;
    end else begin
      work_r <= work_s;
      rem_r  <= rem_s;
      ext_r  <= ext_s;
      src_r  <= src_s;
      ill_r  <= ill_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    rem_s   = rem_r;
    ext_s   = ext_r;
    src_s   = src_r;
    ill_s   = ill_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          src_s   = op_s;
          ill_s   = (op_s == 2'b11);
          state_s = DONE;
          case (op_s)
            2'b00: begin
`ifdef IMM_FAST_ROT_EN
              ext_s = rotr(imm8_s, rot2_s);
`else
              work_s = imm8_s;
              rem_s  = rot2_s;
              if (rot2_s == 6'd0) begin
                ext_s = imm8_s;
              end else begin
                state_s = ROTATE;
              end
`endif
            end
            2'b01:   ext_s = {20'd0, Instr[11:0]};
            2'b10:   ext_s = {{6{Instr[23]}}, Instr[23:0], 2'b00};
            2'b11:   ext_s = 32'd0;
            default: ext_s = 32'd0;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ROTATE: begin
        work_s = work_rot_s;
        rem_s  = rem_dec_s;
        if (rem_dec_s == 6'd0) begin
          ext_s   = work_rot_s;
          state_s = DONE;
        end else begin
          state_s = ROTATE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign ExtImm    = ext_r;
  assign ImmSrc    = src_r;
  assign illegal   = ill_r;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Self-checking bench for imm_ext_ctrl: directed plan cases plus random words against a reference model.
module tb_imm_ext_ctrl;

  localparam int ROT_STEP = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] ExtImm;
  logic        busy;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  imm_ext_ctrl #(.ROT_STEP(ROT_STEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .out_valid(out_valid), .out_ready(out_ready),
    .ImmSrc(ImmSrc), .ExtImm(ExtImm), .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed straight from the architectural rules
  function automatic logic [31:0] m_imm(input logic [31:0] w);
    int unsigned r;
    logic [31:0] v;
    case (w[27:26])
      2'b00: begin
        v = {24'd0, w[7:0]};
        r = 2 * int'(w[11:8]);
        if (r != 0) v = (v >> r) | (v << (32 - r));
        return v;
      end
      2'b01:   return {20'd0, w[11:0]};
      2'b10:   return 32'(signed'(w[23:0])) << 2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int m_lat(input logic [31:0] w);
    int r2;
    r2 = 2 * int'(w[11:8]);
`ifdef IMM_FAST_ROT_EN
    return 1;
`else
    if (w[27:26] == 2'b00 && r2 != 0) return 1 + (r2 + ROT_STEP - 1) / ROT_STEP;
    return 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ExtImm"}, ExtImm, 32'd0);
    check({tag, "_ImmSrc"}, 32'(ImmSrc), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic offer(input logic [31:0] w);
    check("in_ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    Instr = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [31:0] w);
    int lat;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(m_lat(w)));
    check("ExtImm", ExtImm, m_imm(w));
    check("ImmSrc", 32'(ImmSrc), 32'(w[27:26]));
    check("illegal", 32'(illegal), 32'(w[27:26] == 2'b11));
    check("busy_done", 32'(busy), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
  endtask

  task automatic release_out(input logic [31:0] w, input int hold);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ExtImm", ExtImm, m_imm(w));
      check("hold_ImmSrc", 32'(ImmSrc), 32'(w[27:26]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  task automatic txn(input logic [31:0] w, input int hold);
    offer(w);
    collect(w);
    release_out(w, hold);
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Instr = 32'd0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    txn(32'hE3A010FF, 0);
    txn(32'hE3A014FF, 0);
    txn(32'hE3A00F01, 0);
    check("wrap_const", m_imm(32'hE3A00F01), 32'h00000004);
    txn(32'hE5912ABC, 1);
    txn(32'hEAFFFFFE, 0);
    txn(32'h0C000000, 0);

    // Output stall with a second word offered while busy
    offer(32'hE3A014FF);
    collect(32'hE3A014FF);
    in_valid = 1'b1;
    Instr = 32'hE5912ABC;
    release_out(32'hE3A014FF, 3);
    check("stall_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(32'hE5912ABC);
    release_out(32'hE5912ABC, 0);

    // Asynchronous reset in the middle of a rotation
    offer(32'hE3A01FFF);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    txn(32'hE3A014FF, 0);

    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      offer(w);
      out_ready = ($urandom_range(0, 1) == 1);
      collect(w);
      release_out(w, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
